// File: rtl/alu_result_buffer.sv
//==============================================================================
// Module   : alu_result_buffer
// Purpose  : Result stage behind the ALU. Each accepted ALU result
//            {opcode, Zhigh, Zlow} is queued in a small FIFO. The head entry is
//            presented to the bus/writeback side through a valid/ready
//            handshake as Zlow plus zero/negative flags. MUL and DIV results
//            are committed into the architectural HI/LO registers when they
//            are popped.
// Ports    : clock      - rising-edge clock
//            clear_n    - asynchronous active-low reset
//            flush      - synchronous discard of every buffered entry
//            in_valid   - ALU result valid this cycle
//            in_ready   - buffer can accept an entry
//            opcode     - ALU opcode of the incoming result
//            Zhigh/Zlow - ALU upper/lower result words
//            out_valid  - head entry available
//            out_ready  - consumer takes the head entry
//            out_opcode - head opcode        (0 while empty)
//            out_data   - head Zlow          (0 while empty)
//            out_zero   - head Zlow == 0     (0 while empty)
//            out_neg    - head Zlow sign bit (0 while empty)
//            hi/lo      - architectural HI/LO registers
//            count      - number of occupied entries
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_result_buffer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 2,       // power of two, >= 2
    parameter logic [4:0]  OP_MUL = 5'b01111,
    parameter logic [4:0]  OP_DIV = 5'b10000
) (
    input  logic                     clock,
    input  logic                     clear_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               opcode,
    input  logic [WIDTH-1:0]         Zhigh,
    input  logic [WIDTH-1:0]         Zlow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_opcode,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [WIDTH-1:0]         hi,
    output logic [WIDTH-1:0]         lo,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_CW = c_AW + 1;

    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE   = 1;
    localparam logic [c_AW-1:0] c_PTR_ONE   = 1;

    // Pointer and occupancy state
    logic [c_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0]  count_q,  count_d;

    // Architectural HI/LO
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr,
    // so it carries no reset.
    logic [4:0]       mem_op_q [DEPTH];
    logic [WIDTH-1:0] mem_hi_q [DEPTH];
    logic [WIDTH-1:0] mem_lo_q [DEPTH];

    logic             w_not_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_commit;
    logic [4:0]       w_head_op;
    logic [WIDTH-1:0] w_head_hi;
    logic [WIDTH-1:0] w_head_lo;

    //--------------------------------------------------------------------------
    // Handshake qualification
    //--------------------------------------------------------------------------
    assign w_not_empty = (count_q != '0);

    // in_ready depends only on registered occupancy and flush, never on
    // out_ready: a full buffer does not accept even if a pop happens this cycle.
    assign in_ready    = (count_q < c_DEPTH_CNT) & ~flush;
    assign w_push      = in_valid & in_ready;

    // A pop that coincides with flush is discarded, so it must not commit.
    assign w_pop       = w_not_empty & out_ready & ~flush;

    assign w_head_op   = mem_op_q[rd_ptr_q];
    assign w_head_hi   = mem_hi_q[rd_ptr_q];
    assign w_head_lo   = mem_lo_q[rd_ptr_q];

    assign w_commit    = w_pop & ((w_head_op == OP_MUL) | (w_head_op == OP_DIV));

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_ONE;
                2'b01:   count_d = count_q - c_CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // MUL: {Zhigh,Zlow} -> {HI,LO}; DIV: remainder -> HI, quotient -> LO.
        // Both map the stored words identically.
        if (w_commit) begin
            hi_d = w_head_hi;
            lo_d = w_head_lo;
        end
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_op_q[wr_ptr_q] <= opcode;
            mem_hi_q[wr_ptr_q] <= Zhigh;
            mem_lo_q[wr_ptr_q] <= Zlow;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs: head fields are gated by out_valid so stale storage never
    // shows on the bus while the buffer is empty.
    //--------------------------------------------------------------------------
    assign out_valid  = w_not_empty;
    assign out_opcode = w_not_empty ? w_head_op : 5'd0;
    assign out_data   = w_not_empty ? w_head_lo : '0;
    assign out_zero   = w_not_empty & (w_head_lo == '0);
    assign out_neg    = w_not_empty & w_head_lo[WIDTH-1];
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign count      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
//==============================================================================
// Module   : tb_alu_result_buffer
// Purpose  : Self-checking bench for alu_result_buffer. A stimulus process
//            drives directed scenarios followed by random traffic; a monitor
//            process keeps an abstract queue model of the buffer plus HI/LO,
//            and compares the DUT outputs against it every cycle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_result_buffer;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [4:0]  OP_MUL = 5'b01111;
    localparam logic [4:0]  OP_DIV = 5'b10000;
    localparam logic [4:0]  OP_AND = 5'b00101;
    localparam logic [4:0]  OP_OR  = 5'b00110;
    localparam logic [4:0]  OP_ADD = 5'b00011;
    localparam logic [4:0]  OP_SUB = 5'b00100;

    logic                   clock = 1'b0;
    logic                   clear_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [4:0]             opcode;
    logic [W-1:0]           Zhigh;
    logic [W-1:0]           Zlow;
    logic                   out_valid;
    logic                   out_ready;
    logic [4:0]             out_opcode;
    logic [W-1:0]           out_data;
    logic                   out_zero;
    logic                   out_neg;
    logic [W-1:0]           hi;
    logic [W-1:0]           lo;
    logic [$clog2(DEPTH):0] count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] zh;
        logic [W-1:0] zl;
    } entry_t;

    entry_t       sb[$];        // expected buffer contents, head at index 0
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    alu_result_buffer #(
        .WIDTH  (W),
        .DEPTH  (DEPTH),
        .OP_MUL (OP_MUL),
        .OP_DIV (OP_DIV)
    ) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .Zhigh      (Zhigh),
        .Zlow       (Zlow),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .hi         (hi),
        .lo         (lo),
        .count      (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the next rising edge.
    task automatic drive(input logic v, input logic [4:0] op, input logic [W-1:0] zh,
                         input logic [W-1:0] zl, input logic rdy, input logic fl);
        in_valid  = v;
        opcode    = op;
        Zhigh     = zh;
        Zlow      = zl;
        out_ready = rdy;
        flush     = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, '0, '0, 1'b0, 1'b0);
    endtask

    //--------------------------------------------------------------------------
    // Monitor / scoreboard. At each falling edge the inputs for the coming
    // rising edge are stable, so the model checks the present outputs and then
    // advances by the transfers that edge will perform.
    //--------------------------------------------------------------------------
    always @(negedge clock) begin : mon
        int     n;
        entry_t e;
        if (!clear_n) begin
            sb.delete();
            m_hi = '0;
            m_lo = '0;
        end else begin
            n = sb.size();
            check("count",     64'(count),     64'(n));
            check("out_valid", 64'(out_valid), 64'(n != 0));
            check("in_ready",  64'(in_ready),  64'((n < DEPTH) && !flush));
            check("hi",        64'(hi),        64'(m_hi));
            check("lo",        64'(lo),        64'(m_lo));
            if (n != 0) begin
                check("out_data",   64'(out_data),   64'(sb[0].zl));
                check("out_opcode", 64'(out_opcode), 64'(sb[0].op));
                check("out_zero",   64'(out_zero),   64'(sb[0].zl == 0));
                check("out_neg",    64'(out_neg),    64'(sb[0].zl[W-1]));
            end else begin
                check("empty_data",   64'(out_data),   64'd0);
                check("empty_opcode", 64'(out_opcode), 64'd0);
                check("empty_flags",  64'({out_zero, out_neg}), 64'd0);
            end

            if (flush) begin
                sb.delete();
            end else begin
                if (n != 0 && out_ready) begin
                    e = sb.pop_front();
                    if (e.op == OP_MUL || e.op == OP_DIV) begin
                        m_hi = e.zh;
                        m_lo = e.zl;
                    end
                end
                if (in_valid && n < DEPTH) begin
                    e.op = opcode;
                    e.zh = Zhigh;
                    e.zl = Zlow;
                    sb.push_back(e);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin : stim
        logic [4:0]   rop;
        logic [W-1:0] rzl;
        int           sel;

        clear_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        Zhigh     = '0;
        Zlow      = '0;

        #2;
        check("reset_count",     64'(count),     64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_hilo",      64'({hi, lo}),  64'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        clear_n = 1'b1;

        // 1: single AND result, popped without touching HI/LO
        drive(1'b1, OP_AND, 32'h0, 32'h0000_2280, 1'b0, 1'b0);
        drive(1'b0, 5'd0, '0, '0, 1'b1, 1'b0);
        idle(1);

        // 2: fill to full, third push refused, drain in order
        drive(1'b1, OP_OR,  32'h0, 32'h0000_FF9E, 1'b0, 1'b0);
        drive(1'b1, OP_AND, 32'h0, 32'h0000_2280, 1'b0, 1'b0);
        drive(1'b1, OP_AND, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        drive(1'b0, 5'd0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, '0, '0, 1'b1, 1'b0);
        idle(1);

        // 3: MUL result, negative low word, commits both words on pop
        drive(1'b1, OP_MUL, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0);
        drive(1'b0, 5'd0, '0, '0, 1'b1, 1'b0);
        check("mul_hi", 64'(hi), 64'h1);
        check("mul_lo", 64'(lo), 64'h8000_0000);

        // 4: steady push+pop at count=1 across pointer wrap
        drive(1'b1, OP_ADD, 32'h0, 32'd100, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            drive(1'b1, OP_ADD, 32'h0, 32'(101 + i), 1'b1, 1'b0);
        drive(1'b0, 5'd0, '0, '0, 1'b1, 1'b0);
        idle(1);

        // 5: zero result, then flush with a DIV buffered plus concurrent push/pop
        drive(1'b1, OP_SUB, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, OP_DIV, 32'h7, 32'h3, 1'b0, 1'b0);
        drive(1'b1, OP_ADD, 32'h0, 32'd55, 1'b1, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_hilo",  64'({hi, lo}), {32'h1, 32'h8000_0000});
        idle(1);

        // 6: async reset in the middle of traffic
        drive(1'b1, OP_DIV, 32'h9, 32'h4, 1'b0, 1'b0);
        drive(1'b1, OP_ADD, 32'h0, 32'd77, 1'b1, 1'b0);
        drive(1'b1, OP_ADD, 32'h0, 32'd78, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        clear_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_count",     64'(count),     64'd0);
        check("async_hilo",      64'({hi, lo}),  64'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        clear_n = 1'b1;
        idle(1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 3));
            rop = (sel == 0) ? OP_MUL : (sel == 1) ? OP_DIV : 5'($urandom);
            rzl = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            drive($urandom_range(0, 99) < 60, rop, W'($urandom), rzl,
                  $urandom_range(0, 99) < 55, $urandom_range(0, 29) == 0);
        end

        drive(1'b0, 5'd0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, '0, '0, 1'b1, 1'b0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire
